// File: rtl/mii_pkg.sv
// Shared definitions for the MII/GMII receive deframer.
// Contents: the receive FSM state enum, the preamble and SFD symbols for
// nibble (MII) and byte (GMII) modes, the CRC-32 polynomial and the residue
// that a good frame leaves behind, and a bit-reflection helper.
package mii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } mii_state_t;

    localparam logic [3:0] PRE_NIB  = 4'h5;
    localparam logic [3:0] SFD_NIB  = 4'hD;
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    // Normal (MSB-first) form of the polynomial and of the good-frame residue.
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mii_rx_deframer_if.sv
// Bundle between the PHY receive pins and the deframer's byte stream.
// Handshake: rdy is a one-cycle strobe with no back-pressure; q, and sof on
// the first destination byte, are meaningful only while rdy=1. eof is a
// one-cycle strobe that never coincides with rdy; err and crc_err are
// meaningful only while eof=1. byte_cnt counts bytes of the current frame.
// Modports:
//   master - PHY / stimulus side: drives mii_en, mii_d; observes the rest.
//   slave  - deframer side: samples mii_en, mii_d; drives the byte stream
//            and dbg_state (the live FSM state, for checkers).
interface mii_rx_deframer_if
    import mii_pkg::*;
#(
    parameter int DATA_W = 4
);
    logic              mii_en;
    logic [DATA_W-1:0] mii_d;
    logic              rdy;
    logic [7:0]        q;
    logic              sof;
    logic              eof;
    logic              err;
    logic              crc_err;
    logic [10:0]       byte_cnt;
    mii_state_t        dbg_state;

    modport master (
        output mii_en, mii_d,
        input  rdy, q, sof, eof, err, crc_err, byte_cnt, dbg_state
    );

    modport slave (
        input  mii_en, mii_d,
        output rdy, q, sof, eof, err, crc_err, byte_cnt, dbg_state
    );
endinterface

// File: rtl/mii_rx_crc32.sv
// Byte-wide Ethernet CRC-32 (reflected, LSB-first) accumulator.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, presets the register to all ones
//   clr  - synchronous preset to all ones (start of a new frame)
//   en   - fold d into the register this cycle
//   d    - byte to fold in
//   crc  - current register value (no final inversion)
module mii_rx_crc32
    import mii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);
    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '1;
        end else if (en) begin
            crc <= next_crc(crc, d);
        end
    end
endmodule

// File: rtl/mii_rx_deframer.sv
// MII / GMII receive deframer: strips preamble and SFD, assembles bytes,
// counts them, flags runt/oversize/dribble frames and (optionally) checks
// the FCS.
// Parameters: DATA_W (4 = MII nibbles, 8 = GMII bytes), MAX_BYTES,
//             MIN_BYTES (frame size from first destination byte to last
//             FCS byte).
// Ports:
//   mii_clk - sole clock, rising edge
//   reset   - synchronous active-high reset
//   bus     - mii_rx_deframer_if.slave: mii_en/mii_d in; rdy, q, sof, eof,
//             err, crc_err, byte_cnt, dbg_state out
// Build option: define MII_RX_CRC_EN to instantiate the FCS checker;
// without it crc_err is constant 0.
module mii_rx_deframer
    import mii_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BYTES = 1522,
    parameter int MIN_BYTES = 64
)(
    input logic              mii_clk,
    input logic              reset,
    mii_rx_deframer_if.slave bus
);
    localparam logic [DATA_W-1:0] PRE_VAL = (DATA_W == 4) ? DATA_W'(PRE_NIB) : DATA_W'(PRE_BYTE);
    localparam logic [DATA_W-1:0] SFD_VAL = (DATA_W == 4) ? DATA_W'(SFD_NIB) : DATA_W'(SFD_BYTE);
    localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);
    localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);
    localparam logic [10:0] CNT_SAT = '1;

    mii_state_t  state;
    logic        rdy_r, sof_r, eof_r, err_r, crc_err_r;
    logic [7:0]  q_r;
    logic [10:0] byte_cnt_r;
    logic [3:0]  nib_lo;         // first (low) nibble of the byte in flight
    logic        nib_odd;        // a low nibble is held, waiting for its pair
    logic        first_pending;  // next delivered byte is the first of the frame
    logic        from_data;      // DROP was entered by overflow, so eof is owed
    logic        post_rst;       // first cycle after reset: a busy line is mid-frame
    logic [7:0]  byte_in;
    logic        overflow;
    logic        crc_bad;

    if (DATA_W == 4) begin : g_nib
        assign byte_in = {bus.mii_d[3:0], nib_lo};
    end else if (DATA_W == 8) begin : g_byte
        assign byte_in = bus.mii_d[7:0];
    end else begin : g_bad_width
        $error("mii_rx_deframer: DATA_W must be 4 or 8");
        assign byte_in = '0;
    end

    // A completed byte that would push the count beyond MAX_BYTES.
    assign overflow = !first_pending && (byte_cnt_r >= MAX_CNT);

`ifdef MII_RX_CRC_EN
    logic        crc_clr, crc_en;
    logic [31:0] crc_val;
    assign crc_clr = (state == ST_PREAMBLE) && bus.mii_en && (bus.mii_d == SFD_VAL);
    assign crc_en  = (state == ST_DATA) && bus.mii_en && (DATA_W == 8 || nib_odd) && !overflow;
    mii_rx_crc32 u_crc (
        .clk (mii_clk),
        .rst (reset),
        .clr (crc_clr),
        .en  (crc_en),
        .d   (byte_in),
        .crc (crc_val)
    );
    // The register is kept LSB-first; the residue constant is MSB-first.
    assign crc_bad = (reflect32(crc_val) != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rdy_r         <= 1'b0;
            sof_r         <= 1'b0;
            eof_r         <= 1'b0;
            err_r         <= 1'b0;
            crc_err_r     <= 1'b0;
            q_r           <= 8'h00;
            byte_cnt_r    <= '0;
            nib_lo        <= '0;
            nib_odd       <= 1'b0;
            first_pending <= 1'b0;
            from_data     <= 1'b0;
            post_rst      <= 1'b1;
        end else begin
            rdy_r     <= 1'b0;
            sof_r     <= 1'b0;
            eof_r     <= 1'b0;
            err_r     <= 1'b0;
            crc_err_r <= 1'b0;
            post_rst  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    from_data <= 1'b0;
                    if (bus.mii_en) begin
                        state <= (!post_rst && bus.mii_d == PRE_VAL) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!bus.mii_en) begin
                        state <= ST_IDLE;
                    end else if (bus.mii_d == SFD_VAL) begin
                        state         <= ST_DATA;
                        first_pending <= 1'b1;
                        nib_odd       <= 1'b0;
                    end else if (bus.mii_d != PRE_VAL) begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!bus.mii_en) begin
                        state     <= ST_IDLE;
                        eof_r     <= 1'b1;
                        err_r     <= nib_odd || first_pending || (byte_cnt_r < MIN_CNT);
                        crc_err_r <= crc_bad;
                    end else if (DATA_W == 4 && !nib_odd) begin
                        nib_lo  <= bus.mii_d[3:0];
                        nib_odd <= 1'b1;
                    end else begin
                        nib_odd <= 1'b0;
                        if (overflow) begin
                            state     <= ST_DROP;
                            from_data <= 1'b1;
                        end else begin
                            rdy_r         <= 1'b1;
                            q_r           <= byte_in;
                            sof_r         <= first_pending;
                            first_pending <= 1'b0;
                            if (first_pending) begin
                                byte_cnt_r <= 11'd1;
                            end else if (byte_cnt_r != CNT_SAT) begin
                                byte_cnt_r <= byte_cnt_r + 11'd1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (!bus.mii_en) begin
                        state <= ST_IDLE;
                        if (from_data) begin
                            eof_r <= 1'b1;
                            err_r <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rdy       = rdy_r;
    assign bus.q         = q_r;
    assign bus.sof       = sof_r;
    assign bus.eof       = eof_r;
    assign bus.err       = err_r;
    assign bus.crc_err   = crc_err_r;
    assign bus.byte_cnt  = byte_cnt_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mii_rx_deframer.sv
// Bench for mii_rx_deframer: an MII (DATA_W=4) instance with default sizes
// and a GMII (DATA_W=8) instance with MAX_BYTES=64.
module tb_mii_rx_deframer;
    import mii_pkg::*;

    logic clk = 1'b0;
    logic rst4, rst8;
    always #5 clk = ~clk;

    mii_rx_deframer_if #(.DATA_W(4)) if4 ();
    mii_rx_deframer_if #(.DATA_W(8)) if8 ();

    mii_rx_deframer #(.DATA_W(4)) u4 (.mii_clk(clk), .reset(rst4), .bus(if4));
    mii_rx_deframer #(.DATA_W(8), .MAX_BYTES(64)) u8 (.mii_clk(clk), .reset(rst8), .bus(if8));

`ifdef MII_RX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [19:0] exp_q[$];  // {byte_cnt, sof, q} per expected rdy
    logic [13:0] eof_q[$];  // {check_crc, err, crc_err, byte_cnt} per expected eof
    logic [7:0]  frm[$];
    logic [7:0]  units[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input string who, input logic rdy, input logic [7:0] q, input logic sof,
                       input logic eof, input logic err, input logic crc_err, input logic [10:0] cnt);
        logic [19:0] e;
        logic [13:0] f;
        check({who, "_stray_strobes"}, {29'd0, sof & ~rdy, (err | crc_err) & ~eof, rdy & eof}, 32'd0);
        if (rdy) begin
            check({who, "_rdy_expected"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({who, "_byte"}, {12'd0, cnt, sof, q}, {12'd0, e});
            end
        end
        if (eof) begin
            check({who, "_eof_expected"}, 32'(eof_q.size() > 0), 32'd1);
            if (eof_q.size() > 0) begin
                f = eof_q.pop_front();
                check({who, "_eof_err"}, {31'd0, err}, {31'd0, f[12]});
                check({who, "_eof_byte_cnt"}, {21'd0, cnt}, {21'd0, f[10:0]});
                if (f[13]) check({who, "_eof_crc_err"}, {31'd0, crc_err}, {31'd0, f[11]});
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        mon("u4", if4.rdy, if4.q, if4.sof, if4.eof, if4.err, if4.crc_err, if4.byte_cnt);
        mon("u8", if8.rdy, if8.q, if8.sof, if8.eof, if8.err, if8.crc_err, if8.byte_cnt);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Destination 54:ff:01:21:23:24, fixed source, type 0x0800, random
    // payload, then a correct FCS; total length n bytes.
    task automatic build_frame(input int n);
        logic [7:0]  hdr[14] = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
                                 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
        logic [31:0] c;
        frm.delete();
        foreach (hdr[i]) frm.push_back(hdr[i]);
        while (frm.size() < n - 4) frm.push_back(8'($urandom_range(0, 255)));
        c = 32'hFFFFFFFF;
        foreach (frm[i]) c = crc_upd(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic expect_bytes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({11'(i + 1), (i == 0), frm[i]});
    endtask

    task automatic expect_eof(input bit chk_crc, input bit err, input int n);
        logic [31:0] c;
        logic        bad;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_upd(c, frm[i]);
        bad = CRC_ON && (c != 32'hDEBB20E3);
        eof_q.push_back({chk_crc, err, bad, 11'(n)});
    endtask

    task automatic mk4(input int n_cut);
        units.delete();
        repeat (15) units.push_back(8'h5);
        units.push_back(8'hD);
        foreach (frm[i]) begin
            units.push_back({4'h0, frm[i][3:0]});
            units.push_back({4'h0, frm[i][7:4]});
        end
        repeat (n_cut) void'(units.pop_back());
    endtask

    task automatic mk8();
        units.delete();
        repeat (7) units.push_back(8'h55);
        units.push_back(8'hD5);
        foreach (frm[i]) units.push_back(frm[i]);
    endtask

    task automatic send(input bit use8, input int rst_at);
        foreach (units[i]) begin
            if (use8) begin
                if8.mii_en = 1'b1;
                if8.mii_d  = units[i];
                rst8       = (i == rst_at);
            end else begin
                if4.mii_en = 1'b1;
                if4.mii_d  = units[i][3:0];
            end
            cycle();
            if (use8 && i == rst_at) begin
                check("u8_midframe_rst_byte_cnt", {21'd0, if8.byte_cnt}, 32'd0);
                check("u8_midframe_rst_q", {24'd0, if8.q}, 32'd0);
                check("u8_midframe_rst_state", 32'(if8.dbg_state), 32'(ST_IDLE));
            end
        end
        rst8 = 1'b0;
        if4.mii_en = 1'b0; if4.mii_d = '0;
        if8.mii_en = 1'b0; if8.mii_d = '0;
        repeat (4) cycle();
        check("rdy_queue_drained", 32'(exp_q.size()), 32'd0);
        check("eof_queue_drained", 32'(eof_q.size()), 32'd0);
    endtask

    initial begin
        rst4 = 1'b1; rst8 = 1'b1;
        if4.mii_en = 1'b0; if4.mii_d = '0;
        if8.mii_en = 1'b0; if8.mii_d = '0;
        repeat (3) cycle();
        check("u4_reset_strobes", {27'd0, if4.rdy, if4.sof, if4.eof, if4.err, if4.crc_err}, 32'd0);
        check("u4_reset_q", {24'd0, if4.q}, 32'd0);
        check("u4_reset_byte_cnt", {21'd0, if4.byte_cnt}, 32'd0);
        check("u4_reset_state", 32'(if4.dbg_state), 32'(ST_IDLE));
        check("u8_reset_strobes", {27'd0, if8.rdy, if8.sof, if8.eof, if8.err, if8.crc_err}, 32'd0);
        check("u8_reset_byte_cnt", {21'd0, if8.byte_cnt}, 32'd0);
        rst4 = 1'b0; rst8 = 1'b0;
        repeat (2) cycle();

        // Good 64-byte MII frame.
        build_frame(64); expect_bytes(64); expect_eof(1'b1, 1'b0, 64); mk4(0); send(1'b0, -1);
        check("u4_byte_cnt_holds", {21'd0, if4.byte_cnt}, 32'd64);

        // Same frame with one payload bit flipped after the FCS was computed.
        build_frame(64); frm[20] = frm[20] ^ 8'h08;
        expect_bytes(64); expect_eof(1'b1, 1'b0, 64); mk4(0); send(1'b0, -1);

        // Truncated by one nibble: dribble plus runt.
        build_frame(64); expect_bytes(63); expect_eof(1'b1, 1'b1, 63); mk4(1); send(1'b0, -1);

        // Runt with a valid FCS.
        build_frame(60); expect_bytes(60); expect_eof(1'b1, 1'b1, 60); mk4(0); send(1'b0, -1);

        // Broken preamble 5,5,7,D: silently dropped.
        build_frame(64); mk4(0);
        units = units[12:$];
        units[2] = 8'h7;
        send(1'b0, -1);
        check("u4_byte_cnt_after_drop", {21'd0, if4.byte_cnt}, 32'd60);

        // Next frame is received normally.
        build_frame(64); expect_bytes(64); expect_eof(1'b1, 1'b0, 64); mk4(0); send(1'b0, -1);

        // GMII, MAX_BYTES=64: 70-byte frame overflows after 64 bytes.
        build_frame(70); expect_bytes(64); expect_eof(1'b0, 1'b1, 64); mk8(); send(1'b1, -1);

        // GMII: reset while byte 10 is on the wire; bytes 0..9 already out.
        build_frame(64); expect_bytes(10); mk8(); send(1'b1, 18);

        // GMII: a frame of exactly MAX_BYTES is good.
        build_frame(64); expect_bytes(64); expect_eof(1'b1, 1'b0, 64); mk8(); send(1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mii_rx_deframer.md
MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning PHY data width: 4 = MII nibble mode, 8 = GMII byte mode; other values are illegal (elaboration error).
REQ-002 SHALL have parameter MAX_BYTES, default 1522, meaning the largest legal frame size, counted from the first destination byte through the last CRC byte.
REQ-003 SHALL have parameter MIN_BYTES, default 64, meaning the smallest legal frame size on the same basis.
REQ-004 mii_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mii_en  in  1  receive data valid from the PHY.
REQ-007 mii_d  in  DATA_W  receive data; mii_d[0] is first on the wire (LSB-first).
REQ-008 rdy  out  1  one-cycle strobe: q holds a payload byte.
REQ-009 q  out  8  received byte; valid only while rdy=1.
REQ-010 sof  out  1  asserted with rdy on the first destination byte.
REQ-011 eof  out  1  one-cycle end-of-frame pulse.
REQ-012 err  out  1  frame error; valid while eof=1.
REQ-013 crc_err  out  1  FCS mismatch; valid while eof=1.
REQ-014 byte_cnt  out  11  bytes delivered in the current frame; holds its value after eof until the next sof.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE->PREAMBLE when mii_en=1 and the sampled unit equals 4'h5 (DATA_W=4) or 8'h55 (DATA_W=8); any other value with mii_en=1 -> DROP.
REQ-017 PREAMBLE: on 4'hD (DATA_W=4) or 8'hD5 (DATA_W=8) -> DATA; on the preamble value, stay; on any other value -> DROP; on mii_en=0 -> IDLE with no eof.
REQ-018 DATA, DATA_W=4: the first nibble is placed in q[3:0] and the second in q[7:4]; rdy pulses in the cycle after the edge that samples the second nibble (latency 1).
REQ-019 DATA, DATA_W=8: q=mii_d, with rdy pulsing in the cycle after the sampling edge (latency 1).
REQ-020 byte_cnt SHALL clear to 1 on sof and increment on every rdy; the counter saturates and never wraps.
REQ-021 On mii_en sampled 0 in DATA: eof pulses in the next cycle and the state returns to IDLE; eof never coincides with rdy.
REQ-022 err=1 at eof if any of the following holds: an odd nibble count (dribble; the partial nibble is discarded, no rdy), byte_cnt<MIN_BYTES, or overflow.
REQ-023 Overflow: a byte that would make the count exceed MAX_BYTES is not delivered; the block enters DROP, and eof with err=1 pulses when mii_en falls.
REQ-024 DROP: no rdy is issued; the block returns to IDLE when mii_en=0; eof is issued only if DROP was entered from DATA.
REQ-025 rdy, sof, eof, err and crc_err SHALL be zero in every cycle in which they are not explicitly asserted.

Reset
REQ-026 On reset: state=IDLE, rdy=sof=eof=err=crc_err=0, q=8'h00, byte_cnt=0, and the CRC register is preset to 32'hFFFFFFFF.
REQ-027 Reset asserted mid-frame aborts the frame with no eof; if mii_en=1 at the first edge after reset is released, the block enters DROP.

Configuration
REQ-028 With MII_RX_CRC_EN defined: CRC-32 (polynomial 0x04C11DB7, reflected) runs over every delivered byte, and crc_err=1 at eof if the residue is not 32'hC704DD7B.
REQ-029 Without MII_RX_CRC_EN: no CRC logic is instantiated and crc_err is tied to 0.

Structure
REQ-030 Package mii_pkg SHALL hold the state enum, the preamble and SFD constants, and the CRC polynomial and residue constants.
REQ-031 Sub-module mii_rx_crc32 (byte-wide, one-cycle update, with clear and enable inputs) SHALL be instantiated only under MII_RX_CRC_EN.

Verification
REQ-032 DATA_W=4: 15 nibbles of 4'h5, then 4'hD, dst 54:ff:01:21:23:24, src, type, 46-byte payload, valid FCS -> 64 rdy pulses, first q=8'h54 with sof=1, eof with err=0, crc_err=0, byte_cnt=64.
REQ-033 The same frame with one payload bit flipped (CRC_EN defined) -> eof with crc_err=1, err=0.
REQ-034 The same frame truncated by one nibble -> 63 rdy pulses, eof with err=1.
REQ-035 Preamble 5,5,7,D -> no rdy and no eof; the next valid frame is received normally.
REQ-036 MAX_BYTES=64, 70-byte frame -> exactly 64 rdy pulses, then eof with err=1, byte_cnt=64.
REQ-037 DATA_W=8: 55x7, D5, 64-byte frame; reset pulsed at byte 10 -> no eof for that frame; the following frame is received correctly.
